// File: rtl/ecall_io_ctrl.sv
// ECALL service controller: stalls the core on ECALL, performs print/read/exit
// services, and supplies debounced switch reads to reg_file as an a0 write.
module ecall_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ecall,
  input  logic [31:0]         a7,
  input  logic [31:0]         a0,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                btn_confirm,
  output logic                stop_flag,
  output logic                io_wr_en,
  output logic [31:0]         io_wr_data,
  output logic [31:0]         disp_data,
  output logic                disp_valid,
  output logic                wait_led,
  output logic                halted,
  output logic [1:0]          dbg_state
);

  // Handshake: none; ecall is a same-cycle decode level. The core is frozen
  // while stop_flag is high and io_wr_en qualifies the a0 write in RELEASE.

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [31:0] HI_MASK = ~32'((64'd1 << SW_WIDTH) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t state, state_n;

  logic          btn_s1, btn_s2, btn_acc, btn_acc_q;
  logic [CW-1:0] db_cnt;
  logic          press_pulse;
  logic          mode_signed;

  // Button path: synchronizer, then accept a level only after it has been
  // stable and different from the accepted level for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_acc   <= 1'b0;
      btn_acc_q <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_s1    <= btn_confirm;
      btn_s2    <= btn_s1;
      btn_acc_q <= btn_acc;
      if (btn_s2 != btn_acc) begin
        if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          btn_acc <= ~btn_acc;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + CW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press_pulse = btn_acc & ~btn_acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (ecall) begin
          case (a7)
            32'd5, 32'd12: state_n = S_WAIT;
            32'd10:        state_n = S_HALT;
            default:       state_n = S_RELEASE;
          endcase
        end
      end
      S_WAIT:    if (press_pulse) state_n = S_RELEASE;
      S_RELEASE: state_n = S_IDLE;
      default:   state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_signed <= 1'b0;
      io_wr_en    <= 1'b0;
      io_wr_data  <= 32'd0;
      disp_data   <= 32'd0;
      disp_valid  <= 1'b0;
    end else begin
      if (state == S_IDLE && ecall) begin
        if (a7 == 32'd1) begin
          disp_data  <= a0;
          disp_valid <= 1'b1;
        end
        if (a7 == 32'd5)  mode_signed <= 1'b1;
        if (a7 == 32'd12) mode_signed <= 1'b0;
      end
      if (state == S_WAIT && press_pulse) begin
        io_wr_data <= 32'(switches) |
                      ((mode_signed && switches[SW_WIDTH-1]) ? HI_MASK : 32'd0);
        io_wr_en   <= 1'b1;
      end
      if (state == S_RELEASE) io_wr_en <= 1'b0;
    end
  end

  assign stop_flag = (state == S_IDLE && ecall) || state == S_WAIT || state == S_HALT;
  assign wait_led  = (state == S_WAIT);
  assign halted    = (state == S_HALT);
  assign dbg_state = state;

endmodule
